// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared constants, word type and reset-value helper for gpr_file
//
// Purpose : default geometry of the register file, the register word type,
//           the per-index reset value, and the GPR_ZERO_REG_EN feature switch.
// Macro   : GPR_ZERO_REG_EN - when defined, register 0 reads as zero and ignores writes.
// Ports   : none (package).

package gpr_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;
   localparam int DEPTH_DEF  = 8;

   typedef logic [DATA_W_DEF-1:0] word_t;

`ifdef GPR_ZERO_REG_EN
   localparam bit ZERO_REG_EN = 1'b1;
`else
   localparam bit ZERO_REG_EN = 1'b0;
`endif

   // Register i resets to its own index; callers truncate to their DATA_W.
   function automatic logic [31:0] reset_value(input int unsigned idx);
      return 32'(idx);
   endfunction

endpackage

// File: rtl/gpr_read_port.sv
// rtl/gpr_read_port.sv - one registered read port with write-first bypass
//
// Purpose : registers one read of the shared array per cycle, zeroes
//           out-of-range (and, with GPR_ZERO_REG_EN, address 0) reads, and
//           forwards same-edge write data so a read never sees stale contents.
// Macro   : GPR_ZERO_REG_EN (via gpr_pkg::ZERO_REG_EN).
// Ports   : clk, reset        - clock, synchronous active-high reset
//           rd_en, rd_addr    - read request and address
//           mem_word          - array word already selected at rd_addr
//           we, wr_addr, wr_data - write port, observed for bypass
//           rd_data, rd_valid - registered data and one-cycle valid strobe

module gpr_read_port
   import gpr_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] mem_word,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid
);

   logic              in_range;
   logic              zero_hit;
   logic              bypass;
   logic [DATA_W-1:0] next_data;

   always_comb begin
      in_range  = 32'(rd_addr) < DEPTH;
      zero_hit  = ZERO_REG_EN && (rd_addr == '0);
      // A write to an out-of-range address cannot match an in-range read,
      // so the bypass compare needs no range check of its own.
      bypass    = we && (wr_addr == rd_addr);
      next_data = mem_word;
      if (!in_range || zero_hit) begin
         next_data = '0;
      end else if (bypass) begin
         next_data = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= next_data;
         end
      end
   end

endmodule

// File: rtl/gpr_file.sv
// rtl/gpr_file.sv - parametrised register file, two read ports, one write port
//
// Purpose : DEPTH x DATA_W register array with two independent latency-1
//           read ports (A, B) and one write port; reads are write-first.
// Macro   : GPR_ZERO_REG_EN - register 0 hardwired to zero.
// Ports   : clk, reset                    - clock, synchronous active-high reset
//           we, wr_addr, wr_data          - write port (out-of-range writes dropped)
//           rd_en_a, rd_addr_a            - port A request
//           rd_data_a, rd_valid_a         - port A registered data / strobe
//           rd_en_b, rd_addr_b            - port B request
//           rd_data_b, rd_valid_b         - port B registered data / strobe

module gpr_file
   import gpr_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en_a,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   output logic              rd_valid_a,
   input  logic              rd_en_b,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              rd_valid_b
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_ok;
   logic [DATA_W-1:0] mem_word_a;
   logic [DATA_W-1:0] mem_word_b;

   always_comb begin
      wr_ok = we && (32'(wr_addr) < DEPTH) && !(ZERO_REG_EN && (wr_addr == '0));
      // Guard the array lookup so addresses beyond DEPTH never index past the end.
      mem_word_a = '0;
      mem_word_b = '0;
      if (32'(rd_addr_a) < DEPTH) mem_word_a = mem[rd_addr_a];
      if (32'(rd_addr_b) < DEPTH) mem_word_b = mem[rd_addr_b];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= DATA_W'(reset_value(i));
         end
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   gpr_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_port_a (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (rd_en_a),
      .rd_addr  (rd_addr_a),
      .mem_word (mem_word_a),
      .we       (we),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data_a),
      .rd_valid (rd_valid_a)
   );

   gpr_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_port_b (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (rd_en_b),
      .rd_addr  (rd_addr_b),
      .mem_word (mem_word_b),
      .we       (we),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data_b),
      .rd_valid (rd_valid_b)
   );

endmodule

// File: tb/tb_gpr_file.sv
// tb/tb_gpr_file.sv - self-checking bench for gpr_file (DEPTH 8 and DEPTH 6 instances)

module tb_gpr_file;

`ifdef GPR_ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        rd_en_a;
   logic [2:0]  rd_addr_a;
   logic        rd_en_b;
   logic [2:0]  rd_addr_b;

   logic [15:0] rd_data_a,  rd_data_b,  rd_data_a6,  rd_data_b6;
   logic        rd_valid_a, rd_valid_b, rd_valid_a6, rd_valid_b6;

   int total = 0;
   int bad   = 0;

   // Reference model: index 0 = DEPTH 8 instance, index 1 = DEPTH 6 instance.
   logic [15:0] m     [2][8];
   logic [15:0] ed_a  [2];
   logic [15:0] ed_b  [2];
   logic        ev_a  [2];
   logic        ev_b  [2];

   always #5 clk = ~clk;

   gpr_file dut8 (
      .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b)
   );

   gpr_file #(.DATA_W(16), .ADDR_W(3), .DEPTH(6)) dut6 (
      .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a6), .rd_valid_a(rd_valid_a6),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b6), .rd_valid_b(rd_valid_b6)
   );

   function automatic int depth_of(input int k);
      return (k == 0) ? 8 : 6;
   endfunction

   // Value a read of address a returns on this edge, from the pre-edge model contents.
   function automatic logic [15:0] read_exp(input int k, input logic [2:0] a);
      if (int'(a) >= depth_of(k)) return 16'h0;
      if (ZR && a == 3'd0)        return 16'h0;
      if (we && wr_addr == a)     return wr_data;
      return m[k][a];
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic w, input logic [2:0] wa, input logic [15:0] wd,
                       input logic ea, input logic [2:0] aa, input logic eb, input logic [2:0] ab);
      reset = r; we = w; wr_addr = wa; wr_data = wd;
      rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            for (int i = 0; i < 8; i++) m[k][i] = 16'(i);
            ed_a[k] = 16'h0; ed_b[k] = 16'h0;
            ev_a[k] = 1'b0;  ev_b[k] = 1'b0;
         end else begin
            ev_a[k] = ea;
            ev_b[k] = eb;
            if (ea) ed_a[k] = read_exp(k, aa);
            if (eb) ed_b[k] = read_exp(k, ab);
            if (w && int'(wa) < depth_of(k) && !(ZR && wa == 3'd0)) m[k][wa] = wd;
         end
      end
      @(posedge clk);
      #1;
      chk("d8_data_a",  rd_data_a,         ed_a[0]);
      chk("d8_data_b",  rd_data_b,         ed_b[0]);
      chk("d8_valid_a", 16'(rd_valid_a),   16'(ev_a[0]));
      chk("d8_valid_b", 16'(rd_valid_b),   16'(ev_b[0]));
      chk("d6_data_a",  rd_data_a6,        ed_a[1]);
      chk("d6_data_b",  rd_data_b6,        ed_b[1]);
      chk("d6_valid_a", 16'(rd_valid_a6),  16'(ev_a[1]));
      chk("d6_valid_b", 16'(rd_valid_b6),  16'(ev_b[1]));
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; wr_addr = 3'd0; wr_data = 16'h0;
      rd_en_a = 1'b0; rd_addr_a = 3'd0; rd_en_b = 1'b0; rd_addr_b = 3'd0;
      @(posedge clk);
      #1;

      // Reset overrides a simultaneous write and reads.
      step(1'b1, 1'b1, 3'd2, 16'h5555, 1'b1, 3'd4, 1'b1, 3'd4);
      chk("rst_data_a", rd_data_a, 16'h0);
      chk("rst_valid_a", 16'(rd_valid_a), 16'h0);

      // Reset contents: reg[i] == i; address 7 out of range on DEPTH 6.
      step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b1, 3'd7);
      chk("tp1_a", rd_data_a, 16'd5);
      chk("tp1_b", rd_data_b, 16'd7);
      chk("tp1_b6", rd_data_b6, 16'd0);
      chk("tp1_vb6", 16'(rd_valid_b6), 16'd1);

      // Write-first bypass, then the stored value seen on the other port.
      step(1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b1, 3'd3, 1'b0, 3'd0);
      chk("bypass_a", rd_data_a, 16'hBEEF);
      step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd3);
      chk("after_b", rd_data_b, 16'hBEEF);

      // Four back-to-back reads of addr 2 on both ports, then two idle cycles.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b1, 3'd2);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd6, 1'b0, 3'd6);
         chk("hold_a", rd_data_a, 16'd2);
      end

      // Out-of-range write on DEPTH 6 is dropped; sweep all addresses afterwards.
      step(1'b0, 1'b1, 3'd7, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd0);
      step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 1'b1, 3'd7);
      chk("oor_a6", rd_data_a6, 16'h0);
      chk("inr_a8", rd_data_a, 16'h1234);
      for (int i = 0; i < 8; i++)
         step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b1, 3'(7 - i));

      // Write then reset with a read in flight; the reset value returns.
      step(1'b0, 1'b1, 3'd1, 16'hAAAA, 1'b0, 3'd0, 1'b0, 3'd0);
      step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 1'b0, 3'd0);
      chk("rst2_valid_a", 16'(rd_valid_a), 16'h0);
      step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 1'b0, 3'd0);
      chk("rst2_read1", rd_data_a, 16'd1);

      // Register 0 write with simultaneous reads of 0 on both ports.
      step(1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 1'b1, 3'd0);
      chk("zero_a", rd_data_a, ZR ? 16'h0 : 16'hFFFF);
      step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 1'b0, 3'd0);
      chk("zero_after", rd_data_a, ZR ? 16'h0 : 16'hFFFF);

      // Random traffic against the model.
      for (int n = 0; n < 500; n++) begin
         step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              16'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
